pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Observes the decode operands, the ID/EX register contents, the EX redirect and the MEM-stage memory handshake.
- Drives write-enable, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Adds a bounded memory-wait state machine with timeout, and stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It resolves load-use and
// redirect hazards combinationally, and freezes the pipe while a data-memory
// access is outstanding. A bounded wait escalates to a sticky error state.
// Stall and flush events are tallied in saturating counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use, redirect, count_flush;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Hazard detection; x0 is never a real dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    redirect = ex_branch_taken || ex_jump;
  end

  // Next-state logic and pipeline control outputs.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mem_error_d  = mem_error_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    count_flush  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // The EX instruction is held, so redirect/load-use are re-evaluated after release.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_hold  = 1'b1;
          ex_mem_hold = 1'b1;
          state_d     = MEM_WAIT;
          wait_d      = 8'd1;
        end else if (redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          count_flush  = 1'b1;
        end else if (load_use) begin
          // One bubble suffices: the load moves on to EX/MEM next cycle.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q >= WAIT_LIMIT) begin
          state_d     = ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        state_d     = ERROR;
        mem_error_d = 1'b1;
      end
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      id_ex_hold   = 1'b0;
      ex_mem_hold  = 1'b0;
      count_flush  = 1'b0;
    end
  end

  // State, wait counter, sticky error and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
      if (!pc_write)   stall_q <= sat_inc(stall_q);
      if (count_flush) flush_q <= sat_inc(flush_q);
    end
  end

  assign mem_error = mem_error_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the stimulus process predicts each cycle's outputs from a
// rule-level model and queues them; a monitor on the falling edge compares.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_jump;
  logic mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold;
  logic mem_error;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [5:0] ctl;   // pc_write, if_id_write, if_id_flush, bubble, hold, ex_mem_hold
    bit         regs_known;
    logic [1:0] st;
    logic       err;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: pipeline mode is "running", "waiting on memory" or "dead".
  int  m_mode = 0;     // 0 run, 1 waiting, 2 dead
  int  m_waited = 0;   // cycles already charged to the current memory wait
  int  m_stalls = 0;
  int  m_flushes = 0;
  bit  m_err = 0;
  bit  m_known = 0;

  task automatic cycle(input int tag, input bit rst,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit mrd, input int rd, input bit bt, input bit jmp,
                       input bit mreq, input bit mrdy);
    exp_t e;
    bit lu, rdir, frozen;
    reset = rst; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mrd; ex_rd = 5'(rd); ex_branch_taken = bt; ex_jump = jmp;
    mem_req = mreq; mem_ready = mrdy;
    lu = mrd && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    rdir = bt || jmp;
    e.tag = tag; e.regs_known = m_known;
    e.st = 2'(m_mode); e.err = m_err; e.sc = m_stalls; e.fc = m_flushes;
    frozen = (m_mode != 0) || (mreq && !mrdy);
    if (rst)            e.ctl = 6'b001100;
    else if (frozen)    e.ctl = 6'b000011;
    else if (rdir)      e.ctl = 6'b111100;
    else if (lu)        e.ctl = 6'b000100;
    else                e.ctl = 6'b110000;
    exp_q.push_back(e);
    // Advance model to the state after this clock edge.
    if (rst) begin
      m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0; m_err = 0; m_known = 1;
    end else begin
      if (!e.ctl[5] && m_stalls < SAT) m_stalls++;
      if (m_mode == 0) begin
        if (mreq && !mrdy) begin m_mode = 1; m_waited = 1; end
        else if (rdir && m_flushes < SAT) m_flushes++;
      end else if (m_mode == 1) begin
        if (mrdy) begin m_mode = 0; m_waited = 0; end
        else if (m_waited >= TO) begin m_mode = 2; m_err = 1; end
        else m_waited++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int tag);
    cycle(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare one prediction per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = exp_q.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl tag=%0d t=%0t got=%b want=%b", e.tag, $time, act, e.ctl);
      end
      if (e.regs_known) begin
        checks++;
        if (state !== e.st || mem_error !== e.err ||
            stall_cnt !== CW'(e.sc) || flush_cnt !== CW'(e.fc)) begin
          errors++;
          $display("FAIL regs tag=%0d t=%0t got st=%0d err=%b sc=%0d fc=%0d want st=%0d err=%b sc=%0d fc=%0d",
                   e.tag, $time, state, mem_error, stall_cnt, flush_cnt,
                   e.st, e.err, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk); #1;
    do_reset(1); do_reset(1);
    idle(2, 1);
    // Load-use on rs2, then release.
    cycle(3, 0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0);
    idle(3, 1);
    // x0 destination never stalls.
    cycle(4, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    idle(4, 1);
    // Redirect beats load-use.
    do_reset(5);
    cycle(5, 0, 0, 0, 5, 1, 1, 5, 0, 1, 0, 0);
    idle(5, 1);
    // Memory wait: ready low 3 cycles then high.
    do_reset(6);
    for (int i = 0; i < 3; i++) cycle(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(6, 2);
    // Timeout to ERROR, stays frozen when ready arrives, reset recovers.
    do_reset(7);
    for (int i = 0; i < 7; i++) cycle(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) cycle(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    do_reset(7);
    idle(7, 1);
    // Ready on the cycle the wait counter hits the limit.
    for (int i = 0; i < TO; i++) cycle(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(8, 1);
    // Stall counter saturation.
    do_reset(9);
    for (int i = 0; i < 20; i++) cycle(9, 0, 7, 1, 0, 0, 1, 7, 0, 0, 0, 0);
    idle(9, 2);
    // Flush counter saturation.
    for (int i = 0; i < 20; i++) cycle(10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(10, 1);
    // Randomized traffic with occasional resets.
    do_reset(11);
    for (int i = 0; i < 3000; i++) begin
      cycle(11, ($urandom_range(0, 99) < 2),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
